axi_adapter_arbiter: RTL and testbench

//  Round-robin arbiter placed directly upstream of the AXI adapter. Multiplexes NR_PORTS cache-side

---
 rtl/axi_adapter_arbiter.sv | 138 +++++++++++++
 tb/tb_axi_adapter_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_adapter_arbiter.sv
// Round-robin arbiter in front of a single AXI adapter. NR_PORTS cache-side
// requesters share one req/gnt/valid interface with one transaction in flight.
// Grant, completion and critical-word strobes go back to the owning port only.
// Read data, response id and critical word are broadcast to all ports.
module axi_adapter_arbiter #(
    parameter int unsigned NR_PORTS     = 2,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned AXI_ID_WIDTH = 10,
    parameter int unsigned XLEN         = 64
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    // requester side
    input  logic [NR_PORTS-1:0]                           req_i,
    input  logic [NR_PORTS-1:0]                           type_i,    // 0: single, 1: cache line
    input  logic [NR_PORTS-1:0][XLEN-1:0]                 addr_i,
    input  logic [NR_PORTS-1:0]                           we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/XLEN-1:0][XLEN-1:0]   wdata_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/XLEN-1:0][XLEN/8-1:0] be_i,
    input  logic [NR_PORTS-1:0][1:0]                      size_i,
    input  logic [NR_PORTS-1:0][AXI_ID_WIDTH-1:0]         id_i,
    output logic [NR_PORTS-1:0]                           gnt_o,
    output logic [NR_PORTS-1:0]                           valid_o,
    output logic [DATA_WIDTH/XLEN-1:0][XLEN-1:0]          rdata_o,
    output logic [AXI_ID_WIDTH-1:0]                       id_o,
    output logic [XLEN-1:0]                               critical_word_o,
    output logic [NR_PORTS-1:0]                           critical_word_valid_o,
    // adapter side
    output logic                                          adp_req_o,
    output logic                                          adp_type_o,
    output logic [XLEN-1:0]                               adp_addr_o,
    output logic                                          adp_we_o,
    output logic [DATA_WIDTH/XLEN-1:0][XLEN-1:0]          adp_wdata_o,
    output logic [DATA_WIDTH/XLEN-1:0][XLEN/8-1:0]        adp_be_o,
    output logic [1:0]                                    adp_size_o,
    output logic [AXI_ID_WIDTH-1:0]                       adp_id_o,
    input  logic                                          adp_gnt_i,
    input  logic                                          adp_valid_i,
    input  logic [DATA_WIDTH/XLEN-1:0][XLEN-1:0]          adp_rdata_i,
    input  logic [AXI_ID_WIDTH-1:0]                       adp_id_i,
    input  logic [XLEN-1:0]                               adp_cw_i,
    input  logic                                          adp_cw_valid_i
);

    // pointer width; a single port still gets a 1-bit (constant 0) pointer
    localparam int unsigned SW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

    state_e        state_q;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] rr_q, rr_next;
    logic          adp_req_q;
    int unsigned   idx;

    // round-robin pick: first requester at or after rr_q, wrapping;
    // scanning from the far end lets the nearest candidate win last
    always_comb begin
        sel_d = rr_q;
        idx   = 0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            idx = 32'(rr_q) + 32'(i);
            if (idx >= NR_PORTS) idx = idx - NR_PORTS;
            if (req_i[SW'(idx)]) sel_d = SW'(idx);
        end
    end

    // next pointer goes one past the port just served
    assign rr_next = (sel_q == SW'(NR_PORTS - 1)) ? '0 : sel_q + SW'(1);

    // transaction FSM; the owner is frozen from IDLE until completion
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            rr_q      <= '0;
            adp_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req_i) begin
                    sel_q     <= sel_d;
                    adp_req_q <= 1'b1;
                    state_q   <= REQ;
                end
                REQ: if (adp_gnt_i) begin
                    adp_req_q <= 1'b0;
                    state_q   <= WAIT_RSP;
                end
                WAIT_RSP: if (adp_valid_i) begin
                    rr_q    <= rr_next;
                    state_q <= IDLE;
                end
                default: begin
                    adp_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // strobes routed to the owner only, and only in the state that expects them
    always_comb begin
        gnt_o                 = '0;
        valid_o               = '0;
        critical_word_valid_o = '0;
        if (state_q == REQ) gnt_o[sel_q] = adp_gnt_i;
        if (state_q == WAIT_RSP) begin
            valid_o[sel_q]               = adp_valid_i;
            critical_word_valid_o[sel_q] = adp_cw_valid_i;
        end
    end

    // request fields follow the owner; stable because requesters hold until gnt
    assign adp_req_o   = adp_req_q;
    assign adp_type_o  = type_i[sel_q];
    assign adp_addr_o  = addr_i[sel_q];
    assign adp_we_o    = we_i[sel_q];
    assign adp_wdata_o = wdata_i[sel_q];
    assign adp_be_o    = be_i[sel_q];
    assign adp_size_o  = size_i[sel_q];
    assign adp_id_o    = id_i[sel_q];

    // response payload is broadcast; ports qualify it with their own strobe
    assign rdata_o         = adp_rdata_i;
    assign id_o            = adp_id_i;
    assign critical_word_o = adp_cw_i;

`ifndef SYNTHESIS
    // adapter strobes outside their state are dropped; flag them
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        adp_valid_i |-> state_q == WAIT_RSP)
        else $warning("adp_valid_i outside WAIT_RSP ignored");
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        adp_gnt_i |-> state_q == REQ)
        else $warning("adp_gnt_i outside REQ ignored");
`endif

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// Bench for axi_adapter_arbiter: directed transactions through a small adapter
// model, expected grants/responses/critical words queued at issue time and
// checked by a negedge monitor. A 3-port instance covers pointer wrap.
module tb_axi_adapter_arbiter;
    localparam int NP = 2, DW = 256, IW = 10, XL = 64, NW = DW / XL;

    typedef struct {
        int                         port;
        logic                       typ;
        logic [XL-1:0]              addr;
        logic                       we;
        logic [NW-1:0][XL-1:0]      wdata;
        logic [NW-1:0][XL/8-1:0]    be;
        logic [1:0]                 size;
        logic [IW-1:0]              id;
    } txn_t;
    typedef struct { int port; logic [IW-1:0] id; logic [NW-1:0][XL-1:0] rdata; } rsp_t;
    typedef struct { int port; logic [XL-1:0] cw; } cw_t;

    logic clk = 0, rst_n;
    always #5 clk = ~clk;

    logic [NP-1:0] req, typ, we, gnt, vld, cwv;
    logic [NP-1:0][XL-1:0] addr;
    logic [NP-1:0][NW-1:0][XL-1:0] wdata;
    logic [NP-1:0][NW-1:0][XL/8-1:0] be;
    logic [NP-1:0][1:0] size;
    logic [NP-1:0][IW-1:0] id;
    logic [NW-1:0][XL-1:0] rdata, adp_wdata, adp_rdata;
    logic [IW-1:0] rid, adp_id, adp_rid;
    logic [XL-1:0] cw, adp_addr, adp_cw;
    logic adp_req, adp_type, adp_we, adp_gnt, adp_valid, adp_cwv;
    logic [NW-1:0][XL/8-1:0] adp_be;
    logic [1:0] adp_size;

    axi_adapter_arbiter #(.NR_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .XLEN(XL)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .type_i(typ), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .be_i(be), .size_i(size), .id_i(id), .gnt_o(gnt), .valid_o(vld),
        .rdata_o(rdata), .id_o(rid), .critical_word_o(cw), .critical_word_valid_o(cwv),
        .adp_req_o(adp_req), .adp_type_o(adp_type), .adp_addr_o(adp_addr), .adp_we_o(adp_we),
        .adp_wdata_o(adp_wdata), .adp_be_o(adp_be), .adp_size_o(adp_size), .adp_id_o(adp_id),
        .adp_gnt_i(adp_gnt), .adp_valid_i(adp_valid), .adp_rdata_i(adp_rdata), .adp_id_i(adp_rid),
        .adp_cw_i(adp_cw), .adp_cw_valid_i(adp_cwv));

    // 3-port instance, only req/gnt/valid exercised
    logic [2:0] req3, gnt3, vld3, cwv3, z3 = '0;
    logic [2:0][XL-1:0] addr3 = '0;
    logic [2:0][NW-1:0][XL-1:0] wdata3 = '0;
    logic [2:0][NW-1:0][XL/8-1:0] be3 = '0;
    logic [2:0][1:0] size3 = '0;
    logic [2:0][IW-1:0] id3 = '0;
    logic [NW-1:0][XL-1:0] rdata3, adp_wdata3, zline = '0;
    logic [IW-1:0] rid3, adp_id3, zid = '0;
    logic [XL-1:0] cw3, adp_addr3, zword = '0;
    logic adp_req3, adp_type3, adp_we3, adp_gnt3, adp_valid3, zbit = 1'b0;
    logic [NW-1:0][XL/8-1:0] adp_be3;
    logic [1:0] adp_size3;

    axi_adapter_arbiter #(.NR_PORTS(3), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .XLEN(XL)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .type_i(z3), .addr_i(addr3), .we_i(z3),
        .wdata_i(wdata3), .be_i(be3), .size_i(size3), .id_i(id3), .gnt_o(gnt3), .valid_o(vld3),
        .rdata_o(rdata3), .id_o(rid3), .critical_word_o(cw3), .critical_word_valid_o(cwv3),
        .adp_req_o(adp_req3), .adp_type_o(adp_type3), .adp_addr_o(adp_addr3), .adp_we_o(adp_we3),
        .adp_wdata_o(adp_wdata3), .adp_be_o(adp_be3), .adp_size_o(adp_size3), .adp_id_o(adp_id3),
        .adp_gnt_i(adp_gnt3), .adp_valid_i(adp_valid3), .adp_rdata_i(zline), .adp_id_i(zid),
        .adp_cw_i(zword), .adp_cw_valid_i(zbit));

    int n_cmp = 0, n_err = 0;
    txn_t exp_gnt[$], rq0[$], rq1[$];
    rsp_t exp_rsp[$];
    cw_t  exp_cw[$];
    int   exp3g[$], exp3v[$];

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NW-1:0][XL-1:0] line_of(logic [XL-1:0] a);
        logic [NW-1:0][XL-1:0] r;
        for (int w = 0; w < NW; w++) r[w] = a + XL'(w);
        return r;
    endfunction

    function automatic txn_t mk(int p, logic t, logic [XL-1:0] a, logic w, logic [XL-1:0] w0,
                                logic [NW*XL/8-1:0] b, logic [1:0] s, logic [IW-1:0] i);
        txn_t x;
        x.port = p; x.typ = t; x.addr = a; x.we = w; x.be = b; x.size = s; x.id = i;
        for (int k = 0; k < NW; k++) x.wdata[k] = w0 + XL'(k);
        return x;
    endfunction

    // ---------------- adapter model ----------------
    int gnt_dly = 0, rsp_dly = 1, cw_at = 1, a_st = 0, a_cnt = 0;
    bit cw_en = 0;
    logic [XL-1:0] cw_val = '0, a_addr;
    logic [IW-1:0] a_id;

    // answers adp_req after gnt_dly cycles, completes rsp_dly cycles after gnt
    always @(posedge clk) begin
        #1;
        adp_gnt = 0; adp_valid = 0; adp_cwv = 0;
        if (!rst_n) begin
            a_st = 0; a_cnt = 0;
        end else if (a_st == 0) begin
            if (adp_req) begin
                if (a_cnt >= gnt_dly) begin
                    adp_gnt = 1; a_addr = adp_addr; a_id = adp_id; a_st = 1; a_cnt = 0;
                end else a_cnt++;
            end
        end else begin
            a_cnt++;
            if (cw_en && a_cnt == cw_at) begin adp_cwv = 1; adp_cw = cw_val; end
            if (a_cnt >= rsp_dly) begin
                adp_valid = 1; adp_rid = a_id; adp_rdata = line_of(a_addr); a_st = 0; a_cnt = 0;
            end
        end
    end

    // ---------------- requesters ----------------
    logic [NP-1:0] g_s = '0;

    task automatic drive(int p, txn_t t);
        typ[p] = t.typ; addr[p] = t.addr; we[p] = t.we; wdata[p] = t.wdata;
        be[p] = t.be; size[p] = t.size; id[p] = t.id;
    endtask

    // hold each queued transaction until its grant is seen, then load the next
    always @(posedge clk) begin
        #1;
        if (!rst_n) req = '0;
        else begin
            if (req[0] && g_s[0]) begin void'(rq0.pop_front()); req[0] = 0; end
            if (!req[0] && rq0.size() > 0) begin drive(0, rq0[0]); req[0] = 1; end
            if (req[1] && g_s[1]) begin void'(rq1.pop_front()); req[1] = 0; end
            if (!req[1] && rq1.size() > 0) begin drive(1, rq1[0]); req[1] = 1; end
        end
    end

    task automatic issue(txn_t t);
        if (t.port == 0) rq0.push_back(t); else rq1.push_back(t);
    endtask

    task automatic expect_txn(txn_t t);
        rsp_t r;
        exp_gnt.push_back(t);
        r.port = t.port; r.id = t.id; r.rdata = line_of(t.addr);
        exp_rsp.push_back(r);
    endtask

    // ---------------- monitor ----------------
    bit prev_g = 0;
    txn_t eg; rsp_t er; cw_t ec;
    int p3;

    // compare every strobe against the head of its expectation queue
    always @(negedge clk) begin
        g_s = gnt;
        if (rst_n) begin
            if (prev_g) chk("adp_req_drop_after_gnt", adp_req, 0);
            prev_g = |gnt;
            if (gnt != 0) begin
                chk("gnt_needs_adp_gnt", adp_gnt, 1);
                if (exp_gnt.size() == 0) chk("gnt_unexpected", gnt, 0);
                else begin
                    eg = exp_gnt.pop_front();
                    chk("gnt_port", gnt, 1 << eg.port);
                    chk("adp_fields", {adp_type, adp_addr, adp_we, adp_wdata, adp_be, adp_size, adp_id},
                        {eg.typ, eg.addr, eg.we, eg.wdata, eg.be, eg.size, eg.id});
                end
            end
            if (vld != 0) begin
                if (exp_rsp.size() == 0) chk("valid_unexpected", vld, 0);
                else begin
                    er = exp_rsp.pop_front();
                    chk("valid_port", vld, 1 << er.port);
                    chk("rsp_id", rid, er.id);
                    chk("rsp_rdata", rdata, er.rdata);
                end
            end
            if (cwv != 0) begin
                if (exp_cw.size() == 0) chk("cw_unexpected", cwv, 0);
                else begin
                    ec = exp_cw.pop_front();
                    chk("cw_port", cwv, 1 << ec.port);
                    chk("cw_word", cw, ec.cw);
                end
            end
            if (gnt3 != 0) begin
                if (exp3g.size() == 0) chk("dut3_gnt_unexpected", gnt3, 0);
                else begin p3 = exp3g.pop_front(); chk("dut3_gnt", gnt3, 1 << p3); end
            end
            if (vld3 != 0) begin
                if (exp3v.size() == 0) chk("dut3_valid_unexpected", vld3, 0);
                else begin p3 = exp3v.pop_front(); chk("dut3_valid", vld3, 1 << p3); end
            end
        end
    end

    task automatic wait_idle(string nm);
        bit done = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #2;
            if (rq0.size() == 0 && rq1.size() == 0 && exp_gnt.size() == 0 && exp_rsp.size() == 0 &&
                exp_cw.size() == 0 && a_st == 0 && adp_req == 0) begin
                done = 1; break;
            end
        end
        if (!done) begin
            chk({nm, "_timeout"}, 0, 1);
            rq0.delete(); rq1.delete(); exp_gnt.delete(); exp_rsp.delete(); exp_cw.delete();
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic run3(logic [2:0] m, int p);
        bit ok = 0;
        exp3g.push_back(p); exp3v.push_back(p);
        @(posedge clk); #1; req3 = m;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (adp_req3) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("dut3_req_timeout", 0, 1);
            req3 = '0; exp3g.delete(); exp3v.delete();
        end else begin
            adp_gnt3 = 1;
            @(posedge clk); #1; adp_gnt3 = 0; req3 = '0; adp_valid3 = 1;
            @(posedge clk); #1; adp_valid3 = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    txn_t t, a0, a1, b0, b1;
    cw_t  c;
    bit   busy;

    initial begin
        rst_n = 0; req = '0; typ = '0; addr = '0; we = '0; wdata = '0; be = '0; size = '0; id = '0;
        adp_gnt = 0; adp_valid = 0; adp_cwv = 0; adp_rdata = '0; adp_rid = '0; adp_cw = '0;
        req3 = '0; adp_gnt3 = 0; adp_valid3 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0); chk("rst_valid", vld, 0);
        chk("rst_cwv", cwv, 0); chk("rst_adp_req", adp_req, 0);
        @(posedge clk); #3 rst_n = 1;
        wait_idle("start");

        // single read on port0, adapter grants after one wait cycle in REQ
        gnt_dly = 1; rsp_dly = 4;
        t = mk(0, 0, 64'h8000_0010, 0, 0, 32'h0000_00FF, 3, 10'h011);
        expect_txn(t); issue(t);
        wait_idle("single_read");

        // cache-line write on port1, slow grant
        gnt_dly = 2; rsp_dly = 2;
        t = mk(1, 1, 64'h8000_0100, 1, 64'h1, 32'hFFFF_FFFF, 3, 10'h022);
        expect_txn(t); issue(t);
        wait_idle("line_write");

        // line read on port1 with critical word
        gnt_dly = 0; rsp_dly = 3; cw_en = 1; cw_at = 1; cw_val = 64'hDEAD;
        t = mk(1, 1, 64'h8000_0200, 0, 0, 0, 3, 10'h033);
        expect_txn(t); c.port = 1; c.cw = 64'hDEAD; exp_cw.push_back(c); issue(t);
        wait_idle("critical_word");
        cw_en = 0;

        // contention from rr=0: port0, port1, port0, port1
        gnt_dly = 0; rsp_dly = 1;
        a0 = mk(0, 0, 64'h1000, 0, 0, 32'hFF, 3, 10'h001);
        b0 = mk(1, 0, 64'h2000, 1, 64'hA0, 32'hF0, 2, 10'h002);
        a1 = mk(0, 1, 64'h1040, 0, 0, 32'hFF, 3, 10'h003);
        b1 = mk(1, 1, 64'h2040, 1, 64'hB0, 32'hFFFF_FFFF, 3, 10'h004);
        expect_txn(a0); expect_txn(b0); expect_txn(a1); expect_txn(b1);
        issue(a0); issue(a1); issue(b0); issue(b1);
        wait_idle("contention");

        // port0 alone moves the pointer to 1
        t = mk(0, 0, 64'h3000, 0, 0, 32'hFF, 3, 10'h005);
        expect_txn(t); issue(t);
        wait_idle("ptr_to_1");

        // reset in WAIT_RSP while the critical word strobe is up
        rsp_dly = 20; cw_en = 1; cw_at = 3; cw_val = 64'hBEEF;
        t = mk(1, 1, 64'h4000, 0, 0, 0, 3, 10'h006);
        exp_gnt.push_back(t); issue(t);
        busy = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #2;
            if (a_st == 1) begin busy = 1; break; end
        end
        if (!busy) chk("reset_wait_busy", 0, 1);
        repeat (3) @(posedge clk);
        #3;
        chk("cw_before_rst", cwv, 2'b10);
        rst_n = 0;
        #1;
        chk("midrst_gnt", gnt, 0); chk("midrst_valid", vld, 0);
        chk("midrst_cwv", cwv, 0); chk("midrst_adp_req", adp_req, 0);
        rq0.delete(); rq1.delete(); exp_gnt.delete(); exp_rsp.delete(); exp_cw.delete();
        cw_en = 0; rsp_dly = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        // pointer restarts at 0: port0 before port1
        a0 = mk(0, 0, 64'h5000, 0, 0, 32'hFF, 3, 10'h007);
        b0 = mk(1, 0, 64'h6000, 0, 0, 32'hFF, 3, 10'h008);
        expect_txn(a0); expect_txn(b0);
        issue(b0); issue(a0);
        wait_idle("after_reset");

        // 3-port pointer behaviour including wrap from 2 to 0
        run3(3'b010, 1);
        run3(3'b111, 2);
        run3(3'b111, 0);
        run3(3'b101, 2);
        repeat (3) @(posedge clk);
        #2;
        chk("dut3_pending", exp3g.size() + exp3v.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
